// File: rtl/rr_stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_stream_mux_pkg
//   Shared constants and helpers for the round-robin stream multiplexer.
//   DEFAULT_NCH / DEFAULT_W : default channel count and per-channel data width.
//   idx_width(n)            : width of a channel index, never less than 1 bit.
// ---------------------------------------------------------------------------
package rr_stream_mux_pkg;

    localparam int DEFAULT_NCH = 4;
    localparam int DEFAULT_W   = 8;

    // A channel index needs clog2(n) bits, but a 1-channel-wide field is
    // still kept at 1 bit so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker.
//   req       : request bits, one per channel
//   ptr       : channel with highest priority this cycle
//   grant     : one-hot grant (all-zero when no request)
//   grant_idx : binary index of the granted channel (0 when none)
//   grant_any : at least one request was granted
// ---------------------------------------------------------------------------
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int NCH = DEFAULT_NCH,
    parameter int IW  = idx_width(DEFAULT_NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  grant_idx,
    output logic           grant_any
);

    int k;

    // Walk the channels starting at ptr and wrapping modulo NCH; the first
    // requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        k         = 0;
        for (int i = 0; i < NCH; i++) begin
            k = (int'(ptr) + i) % NCH;
            if (!grant_any && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = IW'(k);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// ---------------------------------------------------------------------------
// rr_stream_mux
//   Round-robin multiplexer of NCH valid/ready streams onto one registered
//   output stream.
//
//   Handshake: a beat moves on an interface at a rising clk edge where its
//   valid and ready are both high. The output register accepts a new beat
//   whenever it is empty or being drained in the same cycle, which gives
//   full throughput; in_ready never depends on in_data or in_last.
//
//   Ports
//     clk, rst_n            : clock, synchronous active-low reset
//     in_data  [NCH*W]      : channel k data at bits [k*W +: W]
//     in_valid/in_last [NCH]: per-channel valid and end-of-packet
//     in_ready [NCH]        : per-channel accept, at most one bit high
//     out_data/out_last/out_ch/out_valid : registered output beat
//     out_ready             : downstream accept
//
//   Build option: RR_STREAM_MUX_PKT_LOCK_EN keeps the grant on one channel
//   from its first beat until its in_last beat, so packets never interleave.
//   Without it arbitration happens per beat and in_last is plain sideband.
// ---------------------------------------------------------------------------
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int NCH = DEFAULT_NCH,
    parameter  int W   = DEFAULT_W,
    localparam int IW  = idx_width(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH-1:0]   in_last,
    output logic [NCH-1:0]   in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [IW-1:0]    out_ch,
    input  logic             out_ready
);

    logic [W-1:0]   out_data_q,  out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q,  out_last_d;
    logic [IW-1:0]  out_ch_q,    out_ch_d;
    logic [IW-1:0]  rr_ptr_q,    rr_ptr_d;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    logic           lock_q,      lock_d;
    logic [IW-1:0]  lock_ch_q,   lock_ch_d;
`endif

    logic           open;
    logic [NCH-1:0] req;
    logic [NCH-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic           grant_any;
    logic           accept;
    logic [W-1:0]   sel_data;
    logic           sel_last;
    logic [IW-1:0]  nxt_ptr;

    // Output register can take a beat when empty or draining this cycle.
    always_comb begin
        open = !out_valid_q || out_ready;
    end

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    // Mid-packet, only the owning channel may request.
    always_comb begin
        req = in_valid;
        if (lock_q) begin
            req = in_valid & (NCH'(1) << lock_ch_q);
        end
    end
`else
    always_comb begin
        req = in_valid;
    end
`endif

    rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // rst_n gates the grant so nothing is accepted during a reset cycle.
    always_comb begin
        in_ready = (open && rst_n) ? grant : '0;
        accept   = grant_any && open && rst_n;
        sel_data = in_data[int'(grant_idx)*W +: W];
        sel_last = in_last[grant_idx];
        nxt_ptr  = (grant_idx == IW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (accept) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
            out_last_d  = sel_last;
            out_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        // The pointer moves only once the packet closes.
        if (accept) begin
            if (sel_last) begin
                lock_d   = 1'b0;
                rr_ptr_d = nxt_ptr;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant_idx;
            end
        end
`else
        if (accept) begin
            rr_ptr_d = nxt_ptr;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    always_comb begin
        out_data  = out_data_q;
        out_valid = out_valid_q;
        out_last  = out_last_q;
        out_ch    = out_ch_q;
    end

endmodule
